// File: rtl/stage_pkg.sv
// Shared definitions for the stage encoder/decoder pair: datapath defaults,
// key shift-field position and the sequencing FSM state encoding.
package stage_pkg;

    localparam int STAGE_WIDTH  = 16;
    localparam int STAGE_OFFSET = 3;

    // Shift count k lives in key[4:2]; key[1:0] carry no meaning for this stage.
    localparam int KEY_K_MSB = 4;
    localparam int KEY_K_LSB = 2;
    localparam int KEY_K_W   = KEY_K_MSB - KEY_K_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_SUB    = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DONE   = 3'd4
    } stage_state_t;

endpackage

// File: rtl/stage1_dec.sv
// Stage-1 decoder: removes OFFSET, then serially unshifts by k = key[4:2].
// Optional invertibility check (err port) enabled by STAGE1_DEC_ERRCHK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, nothing loaded; start ignored
// ST_LOADED | work holds an encoded word, waiting for start
// ST_SUB    | one cycle: work -= OFFSET, latch err
// ST_SHIFT  | shift work right one bit per cycle until cnt reaches 0
// ST_DONE   | result valid on stg1_dec_out; held until ld or rst
module stage1_dec
    import stage_pkg::*;
#(
    parameter int WIDTH  = STAGE_WIDTH,
    parameter int OFFSET = STAGE_OFFSET
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [4:0]       key_bits,
    input  logic [WIDTH-1:0] input_data,
    input  logic             ld,
    input  logic             start,
    output logic             busy,
    output logic             done,
`ifdef STAGE1_DEC_ERRCHK_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] stg1_dec_out
);

    localparam logic [WIDTH-1:0] OFFSET_W = WIDTH'(OFFSET);

    stage_state_t       state, state_nxt;
    logic [WIDTH-1:0]   work, work_nxt;
    logic [KEY_K_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]   out_nxt;
    logic [WIDTH-1:0]   diff;
    logic               key_unused;

    assign diff       = work - OFFSET_W;
    assign key_unused = ^key_bits[KEY_K_LSB-1:0];

`ifdef STAGE1_DEC_ERRCHK_EN
    logic             err_nxt;
    logic [WIDTH-1:0] low_mask;

    // Bits that the unshift discards; any set bit means the word was never a valid encoding.
    assign low_mask = (WIDTH'(1) << cnt) - WIDTH'(1);
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            state        <= ST_IDLE;
            work         <= '0;
            cnt          <= '0;
            stg1_dec_out <= '0;
`ifdef STAGE1_DEC_ERRCHK_EN
            err          <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            work         <= work_nxt;
            cnt          <= cnt_nxt;
            stg1_dec_out <= out_nxt;
`ifdef STAGE1_DEC_ERRCHK_EN
            err          <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        out_nxt   = stg1_dec_out;
`ifdef STAGE1_DEC_ERRCHK_EN
        err_nxt   = err;
`endif
        // ld wins over start and aborts any decode in flight.
        if (ld) begin
            work_nxt  = input_data;
            state_nxt = ST_LOADED;
`ifdef STAGE1_DEC_ERRCHK_EN
            err_nxt   = 1'b0;
`endif
        end else begin
            unique case (state)
                ST_LOADED: begin
                    if (start) begin
                        cnt_nxt   = key_bits[KEY_K_MSB:KEY_K_LSB];
                        state_nxt = ST_SUB;
                    end
                end
                ST_SUB: begin
                    work_nxt  = diff;
                    state_nxt = ST_SHIFT;
`ifdef STAGE1_DEC_ERRCHK_EN
                    err_nxt   = |(diff & low_mask);
`endif
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        work_nxt = work >> 1;
                        cnt_nxt  = cnt - 1'b1;
                    end else begin
                        out_nxt   = work;
                        state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_SUB) || (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_stage1_dec.sv
// Self-checking bench for stage1_dec: per-cycle comparison against a
// behavioural decode model plus directed vectors with literal expectations.
module tb_stage1_dec;
    import stage_pkg::*;

    localparam int         W   = 16;
    localparam logic [15:0] OFF = 16'd3;

    logic        clk1 = 1'b0;
    logic        rst, ld, start;
    logic [4:0]  key_bits;
    logic [15:0] input_data;
    logic        busy, done;
    logic [15:0] stg1_dec_out;
`ifdef STAGE1_DEC_ERRCHK_EN
    logic        err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk1 = ~clk1;

    stage1_dec #(.WIDTH(W), .OFFSET(3)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .key_bits     (key_bits),
        .input_data   (input_data),
        .ld           (ld),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef STAGE1_DEC_ERRCHK_EN
        .err          (err),
`endif
        .stg1_dec_out (stg1_dec_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: the decoded value is computed in one step at start;
    // only the cycle count until it becomes visible is tracked.
    typedef enum {M_IDLE, M_LOADED, M_RUN, M_DONE} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [15:0] m_work, m_res, m_out, m_diff;
    logic        m_err, m_err_pend;
    int          m_k, m_rem;
    bit          m_valid = 0;

    always @(posedge clk1) begin
        if (rst) begin
            m_phase = M_IDLE; m_work = '0; m_out = '0; m_err = 0; m_rem = 0;
            m_valid = 1;
        end else if (ld) begin
            m_work = input_data; m_phase = M_LOADED; m_err = 0;
        end else begin
            case (m_phase)
                M_LOADED: if (start) begin
                    m_k        = int'(key_bits[4:2]);
                    m_diff     = m_work - OFF;
                    m_res      = m_diff >> m_k;
                    m_err_pend = (int'(m_diff) % (1 << m_k)) != 0;
                    m_rem      = m_k + 1;
                    m_phase    = M_RUN;
                end
                M_RUN: if (m_rem == 0) begin
                    m_phase = M_DONE; m_out = m_res; m_err = m_err_pend;
                end else m_rem--;
                default: ;
            endcase
        end
    end

    always @(negedge clk1) begin
        if (m_valid) begin
            stage_state_t es;
            case (m_phase)
                M_IDLE:   es = ST_IDLE;
                M_LOADED: es = ST_LOADED;
                M_DONE:   es = ST_DONE;
                default:  es = (m_rem == m_k + 1) ? ST_SUB : ST_SHIFT;
            endcase
            chk("cyc_busy",  32'(busy), 32'(m_phase == M_RUN));
            chk("cyc_done",  32'(done), 32'(m_phase == M_DONE));
            chk("cyc_out",   32'(stg1_dec_out), 32'(m_out));
            chk("cyc_state", 32'(dut.state), 32'(es));
`ifdef STAGE1_DEC_ERRCHK_EN
            if (m_phase != M_RUN)
                chk("cyc_err", 32'(err), 32'((m_phase == M_DONE) ? m_err : 1'b0));
`endif
        end
    end

    task automatic load(input logic [15:0] d);
        @(posedge clk1); #1 ld = 1; input_data = d;
        @(posedge clk1); #1 ld = 0;
    endtask

    task automatic start_and_wait(input logic [4:0] key, input logic [15:0] exp,
                                  input int lat, input string nm);
        int n;
        @(posedge clk1); #1 start = 1; key_bits = key;
        @(posedge clk1); #1 start = 0; key_bits = ~key;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk1); #1 n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        chk({nm, "_out"}, 32'(stg1_dec_out), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ld = 0; start = 0; key_bits = '0; input_data = '0;
        repeat (2) @(posedge clk1);
        #1 rst = 0;
        chk("rst_out",   32'(stg1_dec_out), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rst_busy",  32'(busy), 32'h0);

        @(posedge clk1); #1 start = 1; key_bits = 5'b01000;
        @(posedge clk1); #1 start = 0;
        chk("idle_start_ignored", 32'(dut.state), 32'(ST_IDLE));

        load(16'h0013);
        start_and_wait(5'b01000, 16'h0004, 4, "basic_k2");
`ifdef STAGE1_DEC_ERRCHK_EN
        chk("basic_err", 32'(err), 32'h0);
`endif
        load(16'h055B);
        start_and_wait(5'b01100, 16'h00AB, 5, "roundtrip_k3");
        load(16'h0001);
        start_and_wait(5'b00011, 16'hFFFE, 2, "wrap_k0");
        load(16'h0014);
        start_and_wait(5'b01000, 16'h0004, 4, "errchk_k2");
`ifdef STAGE1_DEC_ERRCHK_EN
        chk("errchk_err", 32'(err), 32'h1);
`endif
        load(16'hFFFF);
        start_and_wait(5'b11100, 16'h01FF, 9, "k7");

        @(posedge clk1); #1 start = 1;
        @(posedge clk1); #1 start = 0;
        chk("done_start_ignored", 32'(dut.state), 32'(ST_DONE));

        @(posedge clk1); #1 ld = 1; start = 1; input_data = 16'h0020;
        @(posedge clk1); #1 ld = 0; start = 0;
        chk("ldstart_state", 32'(dut.state), 32'(ST_LOADED));
        chk("ld_keeps_out",  32'(stg1_dec_out), 32'h01FF);

        // Abort: ld arrives two cycles after start.
        @(posedge clk1); #1 start = 1; key_bits = 5'b11100;
        @(posedge clk1); #1 start = 0;
        @(posedge clk1); #1 ld = 1; input_data = 16'h0103;
        @(posedge clk1); #1 ld = 0;
        chk("abort_busy",  32'(busy), 32'h0);
        chk("abort_done",  32'(done), 32'h0);
        chk("abort_state", 32'(dut.state), 32'(ST_LOADED));
        chk("abort_out",   32'(stg1_dec_out), 32'h01FF);
        start_and_wait(5'b11100, 16'h0002, 9, "after_abort");

        // Reset in the middle of SHIFT.
        load(16'h1234);
        @(posedge clk1); #1 start = 1; key_bits = 5'b11100;
        @(posedge clk1); #1 start = 0;
        repeat (2) @(posedge clk1);
        #1 chk("mid_shift_state", 32'(dut.state), 32'(ST_SHIFT));
        rst = 1;
        @(posedge clk1); #1 rst = 0;
        chk("midrst_out",   32'(stg1_dec_out), 32'h0);
        chk("midrst_busy",  32'(busy), 32'h0);
        chk("midrst_done",  32'(done), 32'h0);
        chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("midrst_work",  32'(dut.work), 32'h0);
        chk("midrst_cnt",   32'(dut.cnt), 32'h0);
`ifdef STAGE1_DEC_ERRCHK_EN
        chk("midrst_err",   32'(err), 32'h0);
`endif
        @(posedge clk1); #1 start = 1;
        @(posedge clk1); #1 start = 0;
        @(posedge clk1); #1;
        chk("rst_start_ignored", 32'(dut.state), 32'(ST_IDLE));
        chk("rst_start_busy",    32'(busy), 32'h0);

        @(negedge clk1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stage1_dec.md
STAGE1_DEC -- requirements
Module: stage1_dec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data path width in bits.
REQ-002 The block SHALL have parameter OFFSET, default 3, meaning the additive constant removed before unshifting.
REQ-003 Port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high, sampled on the rising edge of clk1.
REQ-005 Port key_bits, input, 5 bits: key; bits [4:2] give the shift count k (0..7), bits [1:0] are ignored.
REQ-006 Port input_data, input, WIDTH: encoded word to decode.
REQ-007 Port ld, input, 1 bit: load input_data into the work register.
REQ-008 Port start, input, 1 bit: begin decoding the loaded word.
REQ-009 Port busy, output, 1 bit: high while a decode is in progress.
REQ-010 Port done, output, 1 bit: high once a result is valid.
REQ-011 Port stg1_dec_out, output, WIDTH: decoded word.
REQ-012 Port err, output, 1 bit: non-invertible input flag; present only under STAGE1_DEC_ERRCHK_EN.

Function
REQ-013 The block SHALL be an FSM with states IDLE, LOADED, SUB, SHIFT and DONE.
REQ-014 ld high in any non-reset cycle SHALL capture input_data into work, clear done and err, and go to LOADED; this aborts any decode in progress.
REQ-015 ld and start high in the same cycle SHALL act as ld only.
REQ-016 start in LOADED SHALL latch cnt = key_bits[4:2] and go to SUB; start in any other state SHALL be ignored.
REQ-017 SUB (one cycle) SHALL set work = (work - OFFSET) mod 2^WIDTH, then go to SHIFT.
REQ-018 SHIFT SHALL, while cnt != 0, logically shift work right by 1 (zero fill) and decrement cnt, one bit per cycle.
REQ-019 SHIFT with cnt == 0 SHALL load stg1_dec_out with work, set done = 1, and go to DONE.
REQ-020 busy SHALL be 1 exactly in states SUB and SHIFT.
REQ-021 Latency: for start sampled at edge N, done SHALL be high after edge N+k+2; for k=0 this is after edge N+2.
REQ-022 key_bits changes after start is sampled SHALL NOT affect the decode in flight.
REQ-023 stg1_dec_out SHALL hold its value until the next completion; ld SHALL NOT clear it.
REQ-024 DONE SHALL remain until ld or rst; start in DONE SHALL be ignored.
REQ-025 Upper k bits of the result are unrecoverable and SHALL be output as zero.

Reset
REQ-026 rst SHALL take priority over ld and start.
REQ-027 rst SHALL set state = IDLE and clear work, cnt, stg1_dec_out, done, busy and err, including when a decode is mid-operation.

Configuration
REQ-028 With STAGE1_DEC_ERRCHK_EN defined, in SUB err SHALL be set to 1 if the low k bits of (work - OFFSET) are nonzero, and err SHALL be valid together with done.
REQ-029 Without STAGE1_DEC_ERRCHK_EN, port err and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package stage_pkg SHALL hold WIDTH, OFFSET, the key shift-field position [4:2], and the FSM state enum; the encoder stage and this decoder SHALL share it.
REQ-031 The block SHALL be a single module with no sub-module; the serial shifter and counter are inline.

Verification
REQ-032 The bench SHALL cover: ld 0x0013, key 5'b01000 (k=2), start -> after 4 edges done=1, stg1_dec_out=0x0004, err=0.
REQ-033 The bench SHALL cover round trip: encode 0x00AB with k=3 to 0x055B; decode with k=3 -> 0x00AB, done after 5 edges.
REQ-034 The bench SHALL cover wrap: ld 0x0001, k=0, start -> stg1_dec_out=0xFFFE, done after 2 edges.
REQ-035 The bench SHALL cover errchk (macro defined): ld 0x0014, k=2 -> stg1_dec_out=0x0004, err=1; same stimulus without the macro -> same output and no err port.
REQ-036 The bench SHALL cover abort: start with k=7, ld 0x0103 two cycles later -> busy=0, done=0, state LOADED, prior stg1_dec_out unchanged; next start decodes 0x0103.
REQ-037 The bench SHALL cover reset mid-SHIFT: rst for 1 cycle -> all outputs 0, state IDLE; start before ld -> ignored.
